// File: rtl/eight_bit_divider_module.sv
`timescale 1ns/1ps
// Sequential unsigned restoring divider: QUO = A / B, REM = A % B, one quotient bit per clock.
// START/BUSY/DONE handshake; divide-by-zero completes in one cycle with DIV0 set.
module eight_bit_divider_module #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] QUO,
  output logic [WIDTH-1:0] REM,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV0
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_CALC = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   partial;

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH:0]   partial_next;
  logic [WIDTH-1:0] q_next;

  // The sign bit of the widened trial subtraction decides whether the divisor fits.
  always_comb begin
    r_shift      = {partial, dividend[WIDTH-1]};
    trial        = r_shift - {2'b00, divisor};
    fits         = ~trial[WIDTH+1];
    partial_next = fits ? trial[WIDTH:0] : r_shift[WIDTH:0];
    q_next       = {dividend[WIDTH-2:0], fits};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= STATE_IDLE;
      count    <= '0;
      dividend <= '0;
      divisor  <= '0;
      partial  <= '0;
      QUO      <= '0;
      REM      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      DIV0     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (START) begin
            if (B != '0) begin
              dividend <= A;
              divisor  <= B;
              partial  <= '0;
              count    <= '0;
              BUSY     <= 1'b1;
              state    <= STATE_CALC;
            end else begin
              QUO  <= '1;
              REM  <= A;
              DIV0 <= 1'b1;
              DONE <= 1'b1;
            end
          end
        end
        STATE_CALC: begin
          dividend <= q_next;
          partial  <= partial_next;
          count    <= count + 1'b1;
          // The final iteration publishes its result directly from the next-state values.
          if (count == LAST_COUNT) begin
            QUO   <= q_next;
            REM   <= partial_next[WIDTH-1:0];
            DIV0  <= 1'b0;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_divider_module.sv
`timescale 1ns/1ps
// Self-checking bench for eight_bit_divider_module: directed vector table,
// handshake corner sequences, async reset mid-divide and a strided operand sweep.
module tb_eight_bit_divider_module;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             div0;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       div0;
  } vec_t;

  vec_t vecs[13];

  eight_bit_divider_module #(.WIDTH(WIDTH)) dut (
    .CLK  (clk),
    .RST  (rst),
    .START(start),
    .A    (a),
    .B    (b),
    .QUO  (quo),
    .REM  (rem),
    .BUSY (busy),
    .DONE (done),
    .DIV0 (div0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Called on a falling edge: pulses START for one edge and waits (bounded) for DONE.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                               output int n, output int busy_cnt, output logic held_ok);
    logic [7:0] q0, r0;
    logic       d0;
    q0 = quo; r0 = rem; d0 = div0;
    a = va; b = vb; start = 1'b1;
    busy_cnt = 0; held_ok = 1'b1;
    @(negedge clk);
    n = 1;
    start = 1'b0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (quo !== q0 || rem !== r0 || div0 !== d0) held_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [7:0] va, input logic [7:0] vb,
                             input logic [7:0] eq, input logic [7:0] er, input logic ed);
    int n, busy_cnt;
    logic held_ok;
    applyStimulus(va, vb, n, busy_cnt, held_ok);
    checkOutput({tag, "_latency"}, n, (vb == 8'd0) ? 1 : WIDTH + 1);
    checkOutput({tag, "_quo"}, int'(quo), int'(eq));
    checkOutput({tag, "_rem"}, int'(rem), int'(er));
    checkOutput({tag, "_div0"}, int'(div0), int'(ed));
    checkOutput({tag, "_busy_cycles"}, busy_cnt, (vb == 8'd0) ? 0 : WIDTH);
    checkOutput({tag, "_hold"}, int'(held_ok), 1);
  endtask

  initial begin
    int n, busy_cnt, done_seen;
    logic held_ok;
    logic [7:0] ea, eb;

    checks = 0;
    failures = 0;

    vecs[0]  = '{8'd15,  8'd4,   8'd3,   8'd3,   1'b0};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2]  = '{8'd9,   8'd13,  8'd0,   8'd9,   1'b0};
    vecs[3]  = '{8'd17,  8'd0,   8'hFF,  8'd17,  1'b1};
    vecs[4]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
    vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[7]  = '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0};
    vecs[8]  = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0};
    vecs[9]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[10] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0};
    vecs[11] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
    vecs[12] = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #5;
    checkOutput("reset_quo", int'(quo), 0);
    checkOutput("reset_rem", int'(rem), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_div0", int'(div0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Each vector starts on the DONE cycle of the previous one (back-to-back).
    for (int i = 0; i < 13; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].quo, vecs[i].rem, vecs[i].div0);
    end

    // START while busy is ignored; then a back-to-back start on the DONE cycle.
    a = 8'd16; b = 8'd5; start = 1'b1;
    @(negedge clk); n = 1; start = 1'b0;
    @(negedge clk); n++;
    @(negedge clk); n++;
    a = 8'd100; b = 8'd10; start = 1'b1;
    @(negedge clk); n++; start = 1'b0;
    a = 8'd77; b = 8'd3;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ignored_start_latency", n, WIDTH + 1);
    checkOutput("ignored_start_quo", int'(quo), 3);
    checkOutput("ignored_start_rem", int'(rem), 1);
    runAndCheck("b2b", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0);
    @(negedge clk);
    checkOutput("done_single_cycle", int'(done), 0);
    checkOutput("result_holds_quo", int'(quo), 10);

    // Async reset mid-divide after a divide-by-zero left all outputs non-zero.
    runAndCheck("div0_pre_reset", 8'd17, 8'd0, 8'hFF, 8'd17, 1'b1);
    a = 8'd200; b = 8'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset_quo", int'(quo), 0);
    checkOutput("midreset_rem", int'(rem), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_div0", int'(div0), 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checkOutput("abandoned_no_done", done_seen, 0);
    runAndCheck("after_reset", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

    // Strided operand sweep against the bench's own division model.
    for (int ia = 3; ia < 256; ia += 36) begin
      for (int ib = 0; ib < 256; ib += 51) begin
        ea = 8'(ia);
        eb = 8'(ib);
        if (eb == 8'd0)
          runAndCheck($sformatf("sweep_%0d_%0d", ia, ib), ea, eb, 8'hFF, ea, 1'b1);
        else
          runAndCheck($sformatf("sweep_%0d_%0d", ia, ib), ea, eb, ea / eb, ea % eb, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
